// File: rtl/rx_timer_pkg.sv
// +----------------------------------------------------------------------+
// | rx_timer_pkg: shared state encoding and minimum bit-timing limits    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_CYC_PER_BIT   = 2;
  localparam int MIN_BITS_PER_WORD = 1;

endpackage

`default_nettype wire

// File: rtl/flex_counter.sv
// +----------------------------------------------------------------------+
// | flex_counter: up-counter 1..rollover_val with sync clear             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] w_base;
  logic [NUM_CNT_BITS-1:0] w_next;

  // Clear together with enable restarts the count at 1 in the same edge.
  always_comb begin
    w_base = clear ? '0 : r_count;
    w_next = w_base;
    if (count_enable) begin
      if (w_base == rollover_val) begin
        w_next = NUM_CNT_BITS'(1);
      end else begin
        w_next = w_base + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = (r_count == rollover_val);

endmodule

`default_nettype wire

// File: rtl/rx_timer_ctrl.sv
// +----------------------------------------------------------------------+
// | rx_timer_ctrl: receive bit-timing sequencer (strobe/bit_end/done).   |
// | Optional start-config check: define RX_TIMER_CFG_CHK_EN.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rx_timer_ctrl #(
  parameter int CYC_W  = 4,
  parameter int BITS_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CYC_W-1:0]  cycles_per_bit,
  input  logic [BITS_W-1:0] bits_per_word,
  output logic              sample_strobe,
  output logic              bit_end,
  output logic              word_done,
  output logic              busy
`ifdef RX_TIMER_CFG_CHK_EN
  ,
  output logic              cfg_err
`endif
);

  import rx_timer_pkg::*;

  localparam logic [CYC_W-1:0]  C_MIN_P = CYC_W'(MIN_CYC_PER_BIT);
  localparam logic [BITS_W-1:0] C_MIN_N = BITS_W'(MIN_BITS_PER_WORD);

  state_t            r_state;
  state_t            w_state_next;
  logic [CYC_W-1:0]  r_p;
  logic [CYC_W-1:0]  r_h;
  logic [BITS_W-1:0] r_n;
  logic [CYC_W-1:0]  w_p_lat;
  logic [BITS_W-1:0] w_n_lat;
  logic [CYC_W-1:0]  w_cyc_cnt;
  logic [BITS_W-1:0] w_bit_cnt;
  logic              w_cyc_flag;
  logic              w_bit_flag;
  logic              w_start_req;
  logic              w_accept;
  logic              w_run;
  logic              w_last_bit;
  logic              w_clear;
  logic              w_cyc_en;
  logic              w_bit_en;

  assign w_run       = (r_state == RUN);
  assign w_start_req = start && !abort && ((r_state == IDLE) || (r_state == DONE));

`ifdef RX_TIMER_CFG_CHK_EN
  logic w_cfg_bad;
  logic w_refuse;
  logic r_cfg_err;

  assign w_cfg_bad = (cycles_per_bit < C_MIN_P) || (bits_per_word < C_MIN_N);
  assign w_accept  = w_start_req && !w_cfg_bad;
  assign w_refuse  = w_start_req && w_cfg_bad;
  assign w_p_lat   = cycles_per_bit;
  assign w_n_lat   = bits_per_word;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_refuse;
    end
  end

  assign cfg_err = r_cfg_err;
`else
  // Out-of-range settings are raised to the smallest legal word.
  assign w_accept = w_start_req;
  assign w_p_lat  = (cycles_per_bit < C_MIN_P) ? C_MIN_P : cycles_per_bit;
  assign w_n_lat  = (bits_per_word < C_MIN_N) ? C_MIN_N : bits_per_word;
`endif

  // The bit counter only equals N in DONE, so its flag doubles as end-of-word clear.
  assign w_last_bit = (w_bit_cnt == (r_n - BITS_W'(1)));
  assign w_clear    = w_accept || abort || w_bit_flag;
  assign w_cyc_en   = w_accept || (w_run && !abort);
  assign w_bit_en   = w_run && w_cyc_flag && !abort;

  flex_counter #(
    .NUM_CNT_BITS (CYC_W)
  ) u_cyc_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_clear),
    .count_enable  (w_cyc_en),
    .rollover_val  (r_p),
    .count_out     (w_cyc_cnt),
    .rollover_flag (w_cyc_flag)
  );

  flex_counter #(
    .NUM_CNT_BITS (BITS_W)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_clear),
    .count_enable  (w_bit_en),
    .rollover_val  (r_n),
    .count_out     (w_bit_cnt),
    .rollover_flag (w_bit_flag)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_cyc_flag && w_last_bit) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = w_accept ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_p     <= C_MIN_P;
      r_h     <= C_MIN_P >> 1;
      r_n     <= C_MIN_N;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_p <= w_p_lat;
        r_h <= w_p_lat >> 1;
        r_n <= w_n_lat;
      end
    end
  end

  assign sample_strobe = w_run && (w_cyc_cnt == r_h);
  assign bit_end       = w_run && w_cyc_flag;
  assign word_done     = (r_state == DONE);
  assign busy          = (r_state == RUN) || (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_rx_timer_ctrl.sv
// Directed, table-driven bench for rx_timer_ctrl; expected output bits
// are written per cycle as {sample_strobe, bit_end, word_done, busy}.
`default_nettype none

module tb_rx_timer_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       abort;
  logic [3:0] cycles_per_bit;
  logic [3:0] bits_per_word;
  logic       sample_strobe;
  logic       bit_end;
  logic       word_done;
  logic       busy;
  logic       cerr_obs;

  rx_timer_ctrl #(
    .CYC_W  (4),
    .BITS_W (4)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .abort          (abort),
    .cycles_per_bit (cycles_per_bit),
    .bits_per_word  (bits_per_word),
    .sample_strobe  (sample_strobe),
    .bit_end        (bit_end),
    .word_done      (word_done),
    .busy           (busy)
`ifdef RX_TIMER_CFG_CHK_EN
    ,
    .cfg_err        (cerr_obs)
`endif
  );

`ifndef RX_TIMER_CFG_CHK_EN
  assign cerr_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] p;
    logic [3:0] n;
    logic [3:0] exp;
    logic       cerr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic s, input logic a, input logic [3:0] p,
                     input logic [3:0] n, input logic [3:0] e, input logic ce = 1'b0);
    vec_t v;
    v.start = s;
    v.abort = a;
    v.p     = p;
    v.n     = n;
    v.exp   = e;
    v.cerr  = ce;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {sample_strobe, bit_end, word_done, busy, cerr_obs};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (strobe,bit_end,done,busy,cfg_err)", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal P=4 N=2
    add(1,0,4,2,4'b0000); add(0,0,4,2,4'b0001); add(0,0,4,2,4'b1001);
    add(0,0,4,2,4'b0001); add(0,0,4,2,4'b0101); add(0,0,4,2,4'b0001);
    add(0,0,4,2,4'b1001); add(0,0,4,2,4'b0001); add(0,0,4,2,4'b0101);
    add(0,0,4,2,4'b0011); add(0,0,4,2,4'b0000);
    // Back-to-back P=3 N=1, start held through DONE
    add(1,0,3,1,4'b0000); add(1,0,3,1,4'b1001); add(1,0,3,1,4'b0001);
    add(1,0,3,1,4'b0101); add(1,0,3,1,4'b0011); add(0,0,3,1,4'b1001);
    add(0,0,3,1,4'b0001); add(0,0,3,1,4'b0101); add(0,0,3,1,4'b0011);
    add(0,0,3,1,4'b0000);
    // Abort P=5 N=3 in RUN cycle 7
    add(1,0,5,3,4'b0000); add(0,0,5,3,4'b0001); add(0,0,5,3,4'b1001);
    add(0,0,5,3,4'b0001); add(0,0,5,3,4'b0001); add(0,0,5,3,4'b0101);
    add(0,0,5,3,4'b0001); add(0,1,5,3,4'b1001); add(0,0,5,3,4'b0000);
    add(0,0,5,3,4'b0000); add(0,0,5,3,4'b0000);
    // start with abort in IDLE stays IDLE
    add(1,1,5,3,4'b0000); add(0,0,5,3,4'b0000); add(0,0,5,3,4'b0000);
    // P changes 4 -> 8 during RUN, then next start uses 8
    add(1,0,4,1,4'b0000); add(0,0,8,1,4'b0001); add(0,0,8,1,4'b1001);
    add(0,0,8,1,4'b0001); add(0,0,8,1,4'b0101); add(0,0,8,1,4'b0011);
    add(1,0,8,1,4'b0000); add(0,0,8,1,4'b0001); add(0,0,8,1,4'b0001);
    add(0,0,8,1,4'b0001); add(0,0,8,1,4'b1001); add(0,0,8,1,4'b0001);
    add(0,0,8,1,4'b0001); add(0,0,8,1,4'b0001); add(0,0,8,1,4'b0101);
    add(0,0,8,1,4'b0011); add(0,0,8,1,4'b0000);
    // Bad config P=1 N=0
`ifdef RX_TIMER_CFG_CHK_EN
    add(1,0,1,0,4'b0000,1'b0); add(0,0,1,0,4'b0000,1'b1);
    add(0,0,1,0,4'b0000,1'b0); add(0,0,1,0,4'b0000,1'b0);
`else
    add(1,0,1,0,4'b0000); add(0,0,1,0,4'b1001); add(0,0,1,0,4'b0101);
    add(0,0,1,0,4'b0011); add(0,0,1,0,4'b0000);
`endif

    n_rst          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    cycles_per_bit = 4'd4;
    bits_per_word  = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 5'b00000);
    n_rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {vecs[i].exp, vecs[i].cerr});
      start          = vecs[i].start;
      abort          = vecs[i].abort;
      cycles_per_bit = vecs[i].p;
      bits_per_word  = vecs[i].n;
    end

    // Asynchronous reset in the middle of a P=4 N=2 word
    @(posedge clk); #1;
    check("pre_word_idle", 5'b00000);
    start = 1'b1; abort = 1'b0; cycles_per_bit = 4'd4; bits_per_word = 4'd2;
    @(posedge clk); #1;
    check("mid_word_busy", 5'b00010);
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_word_strobe", 5'b10010);
    #2 n_rst = 1'b0;
    #1;
    check("async_reset", 5'b00000);
    @(posedge clk); #1;
    check("reset_hold", 5'b00000);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle0", 5'b00000);
    @(posedge clk); #1;
    check("post_reset_idle1", 5'b00000);

    // Minimum legal word after reset: P=2 N=1
    start = 1'b1; cycles_per_bit = 4'd2; bits_per_word = 4'd1;
    @(posedge clk); #1;
    check("min_cfg_strobe", 5'b10010);
    start = 1'b0;
    @(posedge clk); #1;
    check("min_cfg_bit_end", 5'b01010);
    @(posedge clk); #1;
    check("min_cfg_done", 5'b00110);
    @(posedge clk); #1;
    check("min_cfg_idle", 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_timer_ctrl.md
# rx_timer_ctrl

Bit-timing sequencer for the serial receive path. It drives two up-counters: a cycle-within-bit counter and a bit-within-word counter. From them it generates a one-cycle sample strobe at the middle of each bit and a one-cycle word-done pulse after a programmable number of bits. It sits between the receive control FSM, which issues start/abort, and the shift register, which consumes the strobes.

## Interface
- CYC_W, 4: width of cycles_per_bit and of the cycle counter.
- BITS_W, 4: width of bits_per_word and of the bit counter.

- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a word; sampled only in IDLE or DONE.
- abort  in  1  cancel the current word, return to IDLE.
- cycles_per_bit  in  CYC_W  clocks per bit (P); latched at start.
- bits_per_word  in  BITS_W  bits per word (N); latched at start.
- sample_strobe  out  1  one-cycle pulse at the bit midpoint.
- bit_end  out  1  one-cycle pulse in the last cycle of each bit.
- word_done  out  1  one-cycle pulse after the N-th bit.
- busy  out  1  high in RUN and DONE.
- cfg_err  out  1  present only with RX_TIMER_CFG_CHK_EN; one-cycle pulse.

## Operation
- States: IDLE, RUN, DONE.
  - Reset state is IDLE with cyc_cnt=0 and bit_cnt=0.
  - All outputs are 0 at reset.
- Start acceptance:
  - start=1 in IDLE (and abort=0) latches P and N, latches H = P>>1, clears both counters, and moves to RUN.
  - start=1 in RUN is ignored.
- RUN, cycle counter:
  - cyc_cnt counts 1..P; after P it wraps to 1.
  - The wrap is the flex-style rollover: the value after P is 1, not 0.
- RUN, bit counter:
  - bit_cnt increments in the cycle where cyc_cnt==P.
  - When it reaches N, the next state is DONE.
- Output decode:
  - sample_strobe = (state==RUN && cyc_cnt==H).
  - bit_end = (state==RUN && cyc_cnt==P).
  - word_done = (state==DONE).
  - All outputs decode from registered state and counters only; there is no input-to-output combinational path.
- DONE lasts one cycle.
  - If start=1 and abort=0 in DONE, go directly to RUN with a fresh latch (back-to-back words with no IDLE gap).
  - Otherwise go to IDLE.
- abort=1 in any state forces IDLE on the next edge.
  - Counters clear; no word_done is produced.
  - abort wins over a simultaneous start.
- Changes to cycles_per_bit or bits_per_word while busy have no effect until the next accepted start.
- Counter arithmetic:
  - Counters are unsigned and CYC_W/BITS_W wide.
  - Comparisons are against the latched values; no overflow is possible because wrap occurs at P ≤ 2^CYC_W−1.
- Reset asserted mid-word returns immediately (asynchronously) to the reset values; no pulses are emitted.

## Timing
- Latency: start edge → first RUN cycle is 1 clock.
- Word length: RUN lasts exactly P·N cycles, then DONE for 1 cycle.
- Strobe positions:
  - Strobes fall in RUN cycles k·P+H for k = 0..N−1.
  - bit_end falls in RUN cycles k·P+P.
- Example, P=4, N=2, start sampled at edge 0:
  - RUN covers cycles 1–8.
  - sample_strobe in cycles 2 and 6.
  - bit_end in cycles 4 and 8.
  - word_done in cycle 9.
  - IDLE from cycle 10.
- Minimum legal configuration is P=2 (H=1), N=1.

## Configuration
- RX_TIMER_CFG_CHK_EN defined:
  - A start with P<2 or N==0 is refused: the block stays in (or goes to) IDLE and cfg_err pulses for one cycle.
  - The cfg_err port exists.
- RX_TIMER_CFG_CHK_EN not defined:
  - The cfg_err port is absent.
  - P<2 is latched as 2 and N==0 is latched as 1; the word then runs normally.

## Structure
- Package rx_timer_pkg holds:
  - state_t, a 2-bit enum {IDLE, RUN, DONE}.
  - The constants MIN_CYC_PER_BIT=2 and MIN_BITS_PER_WORD=1.
- Sub-module: both counters are instances of the team's flex_counter.
  - clear comes from the FSM (accept or abort).
  - count_enable is RUN for the cycle counter and cycle-counter rollover for the bit counter.
  - The rollover_val inputs take the latched P and N.
- The FSM, latch registers and output decode live in rx_timer_ctrl itself.

## Test plan
- Reset: hold n_rst=0 mid-word with P=4, N=2 → all outputs 0 immediately; state IDLE after release.
- Nominal: P=4, N=2, start at cycle 0 → sample_strobe in cycles 2 and 6, bit_end in cycles 4 and 8, word_done in cycle 9, busy in cycles 1–9.
- Back-to-back: start held through DONE with P=3, N=1 → word_done in cycle 4; second RUN in cycles 5–7 with sample_strobe in cycle 5; no IDLE cycle between words.
- Abort: P=5, N=3, abort in RUN cycle 7 → IDLE from cycle 8, no word_done; start and abort together in IDLE → stays IDLE.
- Config latch: change P from 4 to 8 during RUN → current word keeps 4-cycle bits; the next start uses 8.
- Bad config: P=1, N=0 → with RX_TIMER_CFG_CHK_EN, cfg_err pulse and no busy; without it, the word runs as P=2, N=1, giving sample_strobe in cycle 1 and word_done in cycle 3.
